// File: rtl/sub_nibble_seq_if.sv
// Operand/result bus of the nibble-serial subtractor sequencer.
// The master drives the request and operands; the slave returns status and the wide result.
interface sub_nibble_seq_if #(
  parameter int NIB = 4
);
  localparam int W = 4 * NIB;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_we;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         c_wy;
  logic         zero;

  modport master (
    output start, a, b, c_we,
    input  busy, done, q, c_wy, zero
  );

  modport slave (
    input  start, a, b, c_we,
    output busy, done, q, c_wy, zero
  );
endinterface

// File: rtl/sub_nibble_seq.sv
// Feeds two W-bit operands, LSB nibble first, through one external 4-bit borrow-chain
// subtractor, carrying the borrow between nibbles and assembling the wide difference.
module sub_nibble_seq #(
  parameter int NIB = 4
) (
  input  logic                clk,
  input  logic                rst,
  sub_nibble_seq_if.slave     bus,
  output logic [3:0]          sub_a,
  output logic [3:0]          sub_b,
  output logic                sub_cin,
  input  logic [3:0]          sub_q,
  input  logic                sub_cout
);
  localparam int W    = 4 * NIB;
  localparam int IDXW = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] idx;
  logic            borrow;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    q_reg;
  logic [W-1:0]    q_next;
  logic            c_wy_reg;
  logic            zero_reg;
  logic            last;

  assign last = (idx == IDXW'(NIB - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs: subtractor inputs are muxed only from registers, so they are stable all cycle
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
    sub_a    = 4'd0;
    sub_b    = 4'd0;
    sub_cin  = 1'b0;
    if (state == RUN) begin
      sub_a   = a_reg[{idx, 2'b00} +: 4];
      sub_b   = b_reg[{idx, 2'b00} +: 4];
      sub_cin = borrow;
    end
  end

  // Result with the current nibble merged in, so zero can see the final nibble
  always_comb begin
    q_next = q_reg;
    q_next[{idx, 2'b00} +: 4] = sub_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      borrow   <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      q_reg    <= '0;
      c_wy_reg <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.a;
            b_reg  <= bus.b;
            borrow <= bus.c_we;
            idx    <= '0;
            q_reg  <= '0;
          end
        end
        RUN: begin
          q_reg  <= q_next;
          borrow <= sub_cout;
          idx    <= idx + IDXW'(1);
          if (last) begin
            c_wy_reg <= sub_cout;
            zero_reg <= (q_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q    = q_reg;
  assign bus.c_wy = c_wy_reg;
  assign bus.zero = zero_reg;
endmodule

// File: tb/tb_sub_nibble_seq.sv
// Directed and random checks of the nibble-serial subtractor sequencer with a behavioural
// 4-bit borrow-chain subtractor attached to its nibble port.
module tb_sub_nibble_seq;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sub_a, sub_b, sub_q;
  logic       sub_cin, sub_cout;
  logic [4:0] diff;

  int tests  = 0;
  int failed = 0;

  sub_nibble_seq_if #(.NIB(NIB)) bus ();

  sub_nibble_seq #(.NIB(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_cin  (sub_cin),
    .sub_q    (sub_q),
    .sub_cout (sub_cout)
  );

  // External 4-bit subtractor: A - B - C_we, borrow out in bit 4
  always_comb begin
    diff = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0000, sub_cin};
  end
  assign sub_q    = diff[3:0];
  assign sub_cout = diff[4];

  always #5 clk = ~clk;

  // Driver only: issues one request and returns the result, latency and borrow-chain errors
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       output logic [W-1:0] qv, output logic cyv, output logic zv,
                       output int lat, output int cin_errs);
    logic prev;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.c_we = cv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; prev = cv; cin_errs = 0;
    while (!bus.done && lat < 20) begin
      if (sub_cin !== prev) cin_errs++;
      prev = sub_cout;
      @(posedge clk); #1;
      lat++;
    end
    qv = bus.q; cyv = bus.c_wy; zv = bus.zero;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_we = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.q, bus.c_wy, bus.zero, sub_a, sub_b, sub_cin} !== '0) begin
      failed++;
      $display("FAIL reset_outputs got busy=%b done=%b q=%h c_wy=%b zero=%b sub_a=%h sub_b=%h sub_cin=%b want all 0",
               bus.busy, bus.done, bus.q, bus.c_wy, bus.zero, sub_a, sub_b, sub_cin);
    end
    rst = 1'b0;
    $display("[TB] reset: outputs idle");
  endtask

  task automatic test_vector(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic [W-1:0] exp_q, input logic exp_cy,
                             input logic exp_z);
    logic [W-1:0] qv; logic cyv, zv; int lat, ce;
    do_op(av, bv, cv, qv, cyv, zv, lat, ce);
    tests++;
    if (lat !== NIB + 1) begin
      failed++; $display("FAIL %s_latency got %0d want %0d", name, lat, NIB + 1);
    end
    tests++;
    if (qv !== exp_q) begin
      failed++; $display("FAIL %s_q got %h want %h", name, qv, exp_q);
    end
    tests++;
    if (cyv !== exp_cy) begin
      failed++; $display("FAIL %s_c_wy got %b want %b", name, cyv, exp_cy);
    end
    tests++;
    if (zv !== exp_z) begin
      failed++; $display("FAIL %s_zero got %b want %b", name, zv, exp_z);
    end
    tests++;
    if (ce !== 0) begin
      failed++; $display("FAIL %s_cin_chain got %0d errors want 0", name, ce);
    end
    $display("[TB] %s: a=%h b=%h c_we=%b -> q=%h c_wy=%b zero=%b lat=%0d", name, av, bv, cv, qv, cyv, zv, lat);
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 16'h5555; bus.b = 16'h1111; bus.c_we = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.busy !== 1'b1 || bus.q !== 16'h0004) begin
      failed++; $display("FAIL midrun_pre got busy=%b q=%h want busy=1 q=0004", bus.busy, bus.q);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.q, bus.c_wy, bus.zero, sub_a, sub_b, sub_cin} !== '0) begin
      failed++;
      $display("FAIL midrun_async_reset got busy=%b done=%b q=%h c_wy=%b zero=%b sub_a=%h sub_b=%h sub_cin=%b want all 0",
               bus.busy, bus.done, bus.q, bus.c_wy, bus.zero, sub_a, sub_b, sub_cin);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL midrun_idle_after got busy=%b want 0", bus.busy);
    end
    $display("[TB] reset_mid_run: async clear checked");
    test_vector("after_reset", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int done_cyc = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'h0001; bus.c_we = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) begin
        bus.start = 1'b1; bus.a = 16'hFFFF;
      end
      if (cyc == 3) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (dones !== 1) begin
      failed++; $display("FAIL busy_done_count got %0d want 1", dones);
    end
    tests++;
    if (done_cyc !== NIB + 1) begin
      failed++; $display("FAIL busy_done_cycle got %0d want %0d", done_cyc, NIB + 1);
    end
    tests++;
    if (bus.q !== 16'h7FFF || bus.c_wy !== 1'b0) begin
      failed++; $display("FAIL busy_result got q=%h c_wy=%b want q=7fff c_wy=0", bus.q, bus.c_wy);
    end
    $display("[TB] start_while_busy: dones=%0d q=%h c_wy=%b", dones, bus.q, bus.c_wy);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av, bv, exp_q;
    logic         cv, prev, exp_cy;
    logic [W:0]   full;
    int           cyc, last_done, wait_n, ce;
    av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.c_we = cv;
    @(posedge clk); #1;
    cyc = 1; last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, cv};
      exp_q  = full[W-1:0];
      exp_cy = full[W];
      prev = cv; ce = 0; wait_n = 0;
      while (!bus.done && wait_n < 20) begin
        if (bus.busy && sub_cin !== prev) ce++;
        if (bus.busy) prev = sub_cout;
        @(posedge clk); #1;
        cyc++; wait_n++;
      end
      tests++;
      if (bus.q !== exp_q || bus.c_wy !== exp_cy || bus.zero !== (exp_q == '0)) begin
        failed++;
        $display("FAIL b2b_result[%0d] a=%h b=%h c=%b got q=%h c_wy=%b zero=%b want q=%h c_wy=%b zero=%b",
                 i, av, bv, cv, bus.q, bus.c_wy, bus.zero, exp_q, exp_cy, (exp_q == '0));
      end
      tests++;
      if (ce !== 0) begin
        failed++; $display("FAIL b2b_cin_chain[%0d] got %0d errors want 0", i, ce);
      end
      if (last_done >= 0) begin
        tests++;
        if (cyc - last_done !== NIB + 2) begin
          failed++; $display("FAIL b2b_interval[%0d] got %0d want %0d", i, cyc - last_done, NIB + 2);
        end
      end
      if (i < 3 || i == 999)
        $display("[TB] b2b[%0d]: a=%h b=%h c_we=%b -> q=%h c_wy=%b", i, av, bv, cv, bus.q, bus.c_wy);
      last_done = cyc;
      // Next operands are presented during DONE and sampled on the following IDLE edge
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
      bus.a = av; bus.b = bv; bus.c_we = cv;
      @(posedge clk); #1;
      cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vector("basic",  16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
    test_vector("ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    test_vector("zero",   16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
